// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Round-robin arbiter that shares the single memory request port among
//   NUM_REQ requesters (decoder at index 0, then edge PEs and vertex units).
//   A requester holds req, receives a one-cycle grant pulse and drives its
//   packet with pkt_valid_in in that same cycle. The packet goes out to
//   memory one cycle later and the port is then held for BUSY_CYCLES cycles.
//   The arbiter also tracks per-requester wait time and raises sticky
//   starvation flags.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   req          request level per requester
//   pkt_in       packets, requester i at bits [i*PKT_W +: PKT_W]
//   pkt_valid_in packet valid per requester (only the winner's bit is used)
//   mem_ready    memory can accept a new transaction
//   grant        one-hot grant pulse
//   mem_pkt      packet to memory (holds its last value when mem_valid=0)
//   mem_valid    mem_pkt valid
//   busy         arbiter is in GRANT, ISSUE or HOLD
//   last_winner  index of the most recent grant
//   proto_err    pulse: the granted requester supplied no valid packet
//   starve_err   sticky starvation flags, cleared only by reset
module mem_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PKT_W       = 32,
    parameter int BUSY_CYCLES = 2,
    parameter int MAX_WAIT    = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*PKT_W-1:0]   pkt_in,
    input  logic [NUM_REQ-1:0]         pkt_valid_in,
    input  logic                       mem_ready,
    output logic [NUM_REQ-1:0]         grant,
    output logic [PKT_W-1:0]           mem_pkt,
    output logic                       mem_valid,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] last_winner,
    output logic                       proto_err,
    output logic [NUM_REQ-1:0]         starve_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ISSUE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [3:0]       hold_cnt;
    logic [7:0]       wait_cnt [NUM_REQ];

    // First set request scanning upward from ptr+1 with wrap-around.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                     input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(p) + k) % NUM_REQ;
            if (!found && r[idx]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Wait counters stick at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign winner = pick_winner(req, rr_ptr);

    // Control FSM: all outputs registered. rr_ptr holds the current winner
    // while in GRANT, so it also selects which packet/valid to sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            mem_valid   <= 1'b0;
            mem_pkt     <= '0;
            busy        <= 1'b0;
            proto_err   <= 1'b0;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            last_winner <= '0;
            hold_cnt    <= '0;
        end else begin
            grant     <= '0;
            mem_valid <= 1'b0;
            proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req && mem_ready) begin
                        grant       <= NUM_REQ'(1) << winner;
                        rr_ptr      <= winner;
                        last_winner <= winner;
                        busy        <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (pkt_valid_in[rr_ptr]) begin
                        mem_pkt   <= pkt_in[int'(rr_ptr)*PKT_W +: PKT_W];
                        mem_valid <= 1'b1;
                        state     <= ISSUE;
                    end else begin
                        proto_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                ISSUE: begin
                    // ISSUE itself is the first occupancy cycle, so HOLD
                    // covers the remaining BUSY_CYCLES-1.
                    hold_cnt <= 4'(BUSY_CYCLES - 1);
                    if (BUSY_CYCLES == 1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - 4'd1;
                    // Leave as the count expires so the next grant lands
                    // BUSY_CYCLES+2 cycles after the previous one.
                    if (hold_cnt <= 4'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Starvation tracking, based on the registered grant pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
            starve_err <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && !grant[i]) begin
                    wait_cnt[i] <= sat_inc(wait_cnt[i]);
                    if (sat_inc(wait_cnt[i]) >= 8'(MAX_WAIT)) begin
                        starve_err[i] <= 1'b1;
                    end
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a schedule-based reference model.
module tb_mem_req_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int BUSY = 2;
    localparam int MAXW = 4;
    localparam int BIG  = 1 << 30;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] pkt_in;
    logic [N-1:0]   pkt_valid_in;
    logic           mem_ready;
    logic [N-1:0]   grant;
    logic [W-1:0]   mem_pkt;
    logic           mem_valid;
    logic           busy;
    logic [1:0]     last_winner;
    logic           proto_err;
    logic [N-1:0]   starve_err;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .NUM_REQ(N), .PKT_W(W), .BUSY_CYCLES(BUSY), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .pkt_in(pkt_in),
        .pkt_valid_in(pkt_valid_in), .mem_ready(mem_ready), .grant(grant),
        .mem_pkt(mem_pkt), .mem_valid(mem_valid), .busy(busy),
        .last_winner(last_winner), .proto_err(proto_err), .starve_err(starve_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a schedule of cycle numbers at which events happen.
    int           cyc       = 0;
    int           m_ptr     = N - 1;
    int           m_win     = 0;
    int           m_lw      = 0;
    int           grant_cyc = -1;
    int           idle_from = 0;
    int           mv_cyc    = -1;
    int           pe_cyc    = -1;
    logic [W-1:0] m_pkt     = '0;
    int           m_wait [N];
    logic [N-1:0] m_starve  = '0;

    function automatic logic [N-1:0] exp_grant(int c);
        logic [N-1:0] g;
        g = '0;
        if (c == grant_cyc) g[m_win] = 1'b1;
        return g;
    endfunction

    // Advance the model over the clock edge that ends cycle 'cyc'.
    task automatic model_edge();
        logic [N-1:0] g;
        int best, best_d, d;
        g = exp_grant(cyc);
        if (reset) begin
            m_ptr = N - 1; m_lw = 0; grant_cyc = -1; idle_from = cyc + 1;
            mv_cyc = -1; pe_cyc = -1; m_pkt = '0; m_starve = '0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !g[i]) m_wait[i] = (m_wait[i] >= 255) ? 255 : m_wait[i] + 1;
                else                 m_wait[i] = 0;
                if (m_wait[i] >= MAXW) m_starve[i] = 1'b1;
            end
            if (cyc == grant_cyc) begin
                if (pkt_valid_in[m_win]) begin
                    m_pkt = pkt_in[m_win*W +: W];
                    mv_cyc = cyc + 1;
                    idle_from = cyc + 1 + BUSY;
                end else begin
                    pe_cyc = cyc + 1;
                    idle_from = cyc + 1;
                end
            end else if (cyc >= idle_from && |req && mem_ready) begin
                best = -1; best_d = N;
                for (int i = 0; i < N; i++) begin
                    d = (i - m_ptr - 1 + 2 * N) % N;   // distance after the pointer
                    if (req[i] && d < best_d) begin best = i; best_d = d; end
                end
                m_win = best; m_ptr = best; m_lw = best;
                grant_cyc = cyc + 1;
                idle_from = BIG;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("grant",       64'(grant),       64'(exp_grant(cyc)));
        chk("mem_valid",   64'(mem_valid),   64'(cyc == mv_cyc));
        chk("mem_pkt",     64'(mem_pkt),     64'(m_pkt));
        chk("busy",        64'(busy),        64'(cyc < idle_from));
        chk("last_winner", 64'(last_winner), 64'(m_lw));
        chk("proto_err",   64'(proto_err),   64'(cyc == pe_cyc));
        chk("starve_err",  64'(starve_err),  64'(m_starve));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    int           gcyc_q [$];
    int           glw_q  [$];
    logic [N-1:0] gg_q   [$];
    logic         found;

    initial begin
        reset = 1'b1; req = '0; pkt_valid_in = '1; mem_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            pkt_in[i*W +: W] = $urandom;
            m_wait[i] = 0;
        end
        step(); step();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);

        // 1: single requester, latency and grant spacing
        reset = 1'b0;
        pkt_in[0 +: W] = 32'hA5A5_0001;
        req = 4'b0001;
        step();
        chk("t1_grant", 64'(grant), 64'(4'b0001));
        step();
        chk("t1_mem_valid", 64'(mem_valid), 64'd1);
        chk("t1_mem_pkt",   64'(mem_pkt),   64'h0000_0000_A5A5_0001);
        step(); step();
        chk("t1_no_early_grant", 64'(grant), 64'd0);
        step();
        chk("t1_second_grant", 64'(grant), 64'(4'b0001));

        // 2: all requesting, rotation from reset
        reset = 1'b1; req = '0; step();
        reset = 1'b0; req = 4'b1111; pkt_valid_in = 4'b1111;
        for (int k = 0; k < 18; k++) begin
            step();
            if (grant != '0) begin
                gcyc_q.push_back(cyc); glw_q.push_back(int'(last_winner)); gg_q.push_back(grant);
            end
        end
        chk("t2_count", 64'(gcyc_q.size()), 64'd5);
        for (int k = 0; k < gcyc_q.size(); k++) begin
            chk("t2_grant", 64'(gg_q[k]),  64'(4'b0001 << (k % 4)));
            chk("t2_lw",    64'(glw_q[k]), 64'(k % 4));
            if (k > 0) chk("t2_gap", 64'(gcyc_q[k] - gcyc_q[k-1]), 64'(BUSY + 2));
        end

        // 3: granted requester without valid
        req = '0;
        for (int k = 0; k < 6; k++) step();
        req = 4'b0100; pkt_valid_in = 4'b1011;
        step();
        chk("t3_grant", 64'(grant), 64'(4'b0100));
        step();
        chk("t3_proto_err", 64'(proto_err), 64'd1);
        chk("t3_mem_valid", 64'(mem_valid), 64'd0);
        chk("t3_busy",      64'(busy),      64'd0);
        req = 4'b1111; pkt_valid_in = 4'b1111;
        step();
        chk("t3_next_from_3", 64'(grant), 64'(4'b1000));

        // 4: memory not ready
        req = '0;
        for (int k = 0; k < 6; k++) step();
        mem_ready = 1'b0; req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t4_no_grant", 64'(grant), 64'd0);
            chk("t4_idle",     64'(busy),  64'd0);
        end
        mem_ready = 1'b1;
        step();
        chk("t4_grant", 64'(grant), 64'(4'b0100));

        // 5: starvation of requester 3
        reset = 1'b1; req = '0; step();
        reset = 1'b0; req = 4'b1001;
        step(); step(); step();
        chk("t5_not_yet", 64'(starve_err[3]), 64'd0);
        mem_ready = 1'b0;
        step();
        chk("t5_set", 64'(starve_err[3]), 64'd1);
        for (int k = 0; k < 6; k++) step();
        mem_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            if (grant[3]) found = 1'b1;
        end
        chk("t5_grant3_seen", 64'(found), 64'd1);
        req = '0;
        step();
        chk("t5_sticky", 64'(starve_err[3]), 64'd1);
        reset = 1'b1; step();
        chk("t5_cleared", 64'(starve_err), 64'd0);

        // 6: reset during HOLD
        reset = 1'b0; req = 4'b1111;
        for (int k = 0; k < 7; k++) step();
        reset = 1'b1;
        step();
        chk("t6_grant",  64'(grant),       64'd0);
        chk("t6_mv",     64'(mem_valid),   64'd0);
        chk("t6_pkt",    64'(mem_pkt),     64'd0);
        chk("t6_busy",   64'(busy),        64'd0);
        chk("t6_lw",     64'(last_winner), 64'd0);
        chk("t6_starve", 64'(starve_err),  64'd0);
        reset = 1'b0;
        step();
        chk("t6_first_winner", 64'(grant), 64'(4'b0001));

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req       = N'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                pkt_valid_in[i]  = ($urandom_range(0, 4) != 0);
                pkt_in[i*W +: W] = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Round-robin arbiter sharing the single memory request port among NUM_REQ requesters: the decoder (index 0), edge PEs and vertex units.
- Implements the Req/grant handshake the decoder uses: the requester holds req, receives a one-cycle grant, and drives its packet with valid in that same cycle.
- Forwards the winning packet to memory one cycle later, then holds the port for a fixed occupancy window.
- Tracks per-requester wait time and flags starvation.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- PKT_W, 32: packet width; equals `packet_size.
- BUSY_CYCLES, 2: port occupancy cycles after issue (1..15).
- MAX_WAIT, 64: requested-but-ungranted cycles that set starvation (2..255).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request level per requester.
- pkt_in  in  NUM_REQ*PKT_W  packets; requester i occupies bits [i*PKT_W +: PKT_W].
- pkt_valid_in  in  NUM_REQ  packet valid per requester.
- mem_ready  in  1  memory can accept a new transaction.
- grant  out  NUM_REQ  one-hot grant pulse.
- mem_pkt  out  PKT_W  packet to memory.
- mem_valid  out  1  mem_pkt valid.
- busy  out  1  arbiter is not in IDLE.
- last_winner  out  $clog2(NUM_REQ)  index of the most recent grant.
- proto_err  out  1  pulse: granted requester gave no valid.
- starve_err  out  NUM_REQ  sticky starvation flags.

Behaviour:
- Reset, with the following values, regardless of state (reset mid-transaction aborts it; nothing is issued):
  - state=IDLE; grant=0; mem_valid=0; mem_pkt=0; busy=0; proto_err=0; starve_err=0.
  - Wait counters = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins the first arbitration.
- All outputs are registered.
- FSM states: IDLE, GRANT, ISSUE, HOLD.
- IDLE:
  - If |req and mem_ready, pick the winner as the first set req scanning upward from pointer+1, with wrap-around.
  - Next cycle: state=GRANT, grant=onehot(winner), pointer=winner, last_winner=winner.
  - Otherwise stay in IDLE. If mem_ready=0, no grant is issued even if requests are pending.
- GRANT (exactly 1 cycle, grant high):
  - Sample pkt_in and pkt_valid_in of the winner.
  - If valid: register mem_pkt=winner packet and mem_valid=1 for the next cycle; go to ISSUE.
  - If not valid: proto_err=1 for the next cycle, mem_valid stays 0, go to IDLE. The pointer still advances.
  - Valid bits of non-winners are ignored.
- ISSUE (1 cycle, mem_valid high):
  - Load counter=BUSY_CYCLES-1.
  - If BUSY_CYCLES==1, go to IDLE; otherwise go to HOLD.
- HOLD: decrement the counter each cycle; go to IDLE when counter==0 at the start of a cycle.
- Latency:
  - req rise (in IDLE, mem_ready=1) to grant: 1 cycle.
  - grant to mem_valid: 1 cycle.
  - Minimum interval between grants: BUSY_CYCLES+2 cycles.
- req is ignored outside IDLE. A requester still asserting req when the FSM returns to IDLE is a new request and competes normally.
  - The decoder drops Req combinationally in its grant cycle, so it is not re-granted.
- Simultaneous requests: round robin only, no fixed priority. With all requesters asserted continuously, grants rotate 0,1,2,…,NUM_REQ-1,0.
- Starvation:
  - Counter i increments (saturating at 255) every cycle that req[i]=1 and grant[i]=0.
  - Counter i clears on grant[i] or when req[i]=0.
  - starve_err[i] is set when counter i reaches MAX_WAIT and stays set until reset.
- busy=1 in GRANT, ISSUE and HOLD.
- mem_pkt holds its last value when mem_valid=0.

Test Plan:
1. Reset, then req=4'b0001 with pkt0=32'hA5A5_0001 and valid held, mem_ready=1, BUSY_CYCLES=2 -> grant=0001 at cycle 1; mem_valid=1 with mem_pkt=32'hA5A5_0001 at cycle 2; next grant no earlier than cycle 5.
2. req=4'b1111 held continuously, all valids=1 -> grants 0001,0010,0100,1000,0001 spaced 4 cycles apart; last_winner 0,1,2,3,0.
3. Requester 2 granted with pkt_valid_in[2]=0 -> proto_err pulse 1 cycle after grant; mem_valid stays 0; FSM back in IDLE; next arbitration starts from index 3.
4. mem_ready=0 for 10 cycles with req=4'b0100 -> no grant, busy=0; grant=0100 one cycle after mem_ready rises.
5. MAX_WAIT=4; requester 0 monopolises the port while req[3] is masked by the test forcing mem_ready low between grants -> starve_err[3] sets at wait count 4 and remains set after req[3] is granted; cleared only by reset.
6. Reset asserted during HOLD -> next cycle all outputs 0, state IDLE, and the pointer returns so requester 0 wins the first arbitration under req=4'b1111.
